// File: rtl/change_dispenser_if.sv
// Bus between the change dispenser and its requester/hopper.
// Signal names match the original port list so existing connections carry over.
interface change_dispenser_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] change_in;
  logic         borrow_in;
  logic         coin_ack;
  logic         coin_valid;
  logic [1:0]   coin_sel;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] coins_out;

  modport master (
    output start, change_in, borrow_in, coin_ack,
    input  coin_valid, coin_sel, busy, done, err, coins_out
  );

  modport slave (
    input  start, change_in, borrow_in, coin_ack,
    output coin_valid, coin_sel, busy, done, err, coins_out
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin dispenser (denominations 5/2/1): one coin per acked cycle,
// with done/err single-cycle pulses and a coin count for the last request.
module change_dispenser #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  change_dispenser_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    DONE     = 2'd2,
    ERR      = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] remaining_q, remaining_d;
  logic [N-1:0] coins_q, coins_d;
  logic [1:0]   sel;
  logic [N-1:0] coin_val;

  // Greedy pick from the current remainder; only meaningful in DISPENSE.
  always_comb begin
    if (remaining_q >= N'(5)) begin
      sel      = 2'b11;
      coin_val = N'(5);
    end else if (remaining_q >= N'(2)) begin
      sel      = 2'b10;
      coin_val = N'(2);
    end else begin
      sel      = 2'b01;
      coin_val = N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      coins_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coins_q     <= coins_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coins_d     = coins_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.borrow_in) begin
            state_d = ERR;
          end else if (bus.change_in == '0) begin
            coins_d = '0;
            state_d = DONE;
          end else begin
            remaining_d = bus.change_in;
            coins_d     = '0;
            state_d     = DISPENSE;
          end
        end
      end
      DISPENSE: begin
        if (bus.coin_ack) begin
          remaining_d = remaining_q - coin_val;
          coins_d     = coins_q + N'(1);
          if (remaining_d == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.coin_valid = (state_q == DISPENSE);
  assign bus.coin_sel   = (state_q == DISPENSE) ? sel : 2'b00;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = (state_q == ERR);
  assign bus.coins_out  = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected coin selections are queued
// at request time and popped as the hopper acknowledges each coin.
module tb_change_dispenser;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [1:0] exp_q[$];

  change_dispenser_if #(.N(N)) bus ();

  change_dispenser #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference greedy breakdown, returns the number of coins queued.
  function automatic int push_greedy(input int amt);
    int r = amt;
    int n = 0;
    while (r > 0) begin
      if (r >= 5)      begin exp_q.push_back(2'b11); r -= 5; end
      else if (r >= 2) begin exp_q.push_back(2'b10); r -= 2; end
      else             begin exp_q.push_back(2'b01); r -= 1; end
      n++;
    end
    return n;
  endfunction

  task automatic idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.coin_valid), 32'd0);
    check({tag, "_sel"},   32'(bus.coin_sel),   32'd0);
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_done"},  32'(bus.done),       32'd0);
    check({tag, "_err"},   32'(bus.err),        32'd0);
  endtask

  // Issue a request and follow it to done. stall: cycles of coin_ack=0 before
  // acking; poke: observed-cycle index at which a stray start(15) is driven.
  task automatic dispense(input string tag, input int amt, input int stall,
                          input int exp_n, input int poke);
    bit fin = 0;
    int st = stall;
    bus.coin_ack  = (st == 0);
    bus.start     = 1'b1;
    bus.change_in = N'(amt);
    bus.borrow_in = 1'b0;
    tick();
    bus.start = 1'b0;
    if (amt == 0) check({tag, "_first_done"}, 32'(bus.done), 32'd1);
    else          check({tag, "_first_valid"}, 32'(bus.coin_valid), 32'd1);
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      if (bus.done) begin
        check({tag, "_left"},   32'(exp_q.size()), 32'd0);
        check({tag, "_coins"},  32'(bus.coins_out), 32'(exp_n));
        check({tag, "_nvalid"}, 32'(bus.coin_valid), 32'd0);
        check({tag, "_nerr"},   32'(bus.err), 32'd0);
        fin = 1;
      end else begin
        check({tag, "_valid"}, 32'(bus.coin_valid), 32'd1);
        check({tag, "_nerr"},  32'(bus.err), 32'd0);
        if (exp_q.size() == 0) begin
          check({tag, "_extra_coin"}, 32'(bus.coin_sel), 32'd0);
        end else begin
          check({tag, "_sel"}, 32'(bus.coin_sel), 32'(exp_q[0]));
          if (bus.coin_ack) void'(exp_q.pop_front());
        end
        bus.start     = (cyc == poke);
        bus.change_in = (cyc == poke) ? N'(15) : N'(amt);
        tick();
        bus.start = 1'b0;
        if (st > 0) begin
          st--;
          if (st == 0) bus.coin_ack = 1'b1;
        end
      end
    end
    if (!fin) check({tag, "_timeout"}, 32'd0, 32'd1);
    exp_q.delete();
    bus.coin_ack = 1'b0;
    tick();
    idle_outputs({tag, "_after"});
    check({tag, "_hold"}, 32'(bus.coins_out), 32'(exp_n));
  endtask

  initial begin
    int n;
    bus.start     = 1'b0;
    bus.change_in = '0;
    bus.borrow_in = 1'b0;
    bus.coin_ack  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_outputs("reset");
    check("reset_coins", 32'(bus.coins_out), 32'd0);

    // 13 -> 5,5,2,1 with ack tied high
    exp_q.push_back(2'b11); exp_q.push_back(2'b11);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    dispense("c13", 13, 0, 4, -1);

    // Borrow: err for one cycle, nothing dispensed, coins_out untouched
    bus.start = 1'b1; bus.change_in = 4'd9; bus.borrow_in = 1'b1; bus.coin_ack = 1'b1;
    tick();
    bus.start = 1'b0; bus.borrow_in = 1'b0;
    check("err_pulse", 32'(bus.err), 32'd1);
    check("err_nvalid", 32'(bus.coin_valid), 32'd0);
    check("err_ndone", 32'(bus.done), 32'd0);
    check("err_busy", 32'(bus.busy), 32'd1);
    check("err_coins", 32'(bus.coins_out), 32'd4);
    tick();
    idle_outputs("err_after");
    check("err_coins_hold", 32'(bus.coins_out), 32'd4);
    bus.coin_ack = 1'b0;

    // Zero change
    dispense("c0", 0, 0, 0, -1);

    // Backpressure: 5 held for 4 cycles, then 2
    exp_q.push_back(2'b11); exp_q.push_back(2'b10);
    dispense("c7_stall", 7, 3, 2, -1);

    // Reset after first ack aborts with no done
    bus.start = 1'b1; bus.change_in = 4'd13; bus.coin_ack = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rst_mid_sel", 32'(bus.coin_sel), 32'd3);
    tick();
    check("rst_mid_sel2", 32'(bus.coin_sel), 32'd3);
    check("rst_mid_coins", 32'(bus.coins_out), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.coin_ack = 1'b0;
    idle_outputs("rst_mid");
    check("rst_mid_coins0", 32'(bus.coins_out), 32'd0);
    tick();
    idle_outputs("rst_mid_next");
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    dispense("c3", 3, 0, 2, -1);

    // Stray start(15) mid-dispense must be ignored
    exp_q.push_back(2'b11); exp_q.push_back(2'b11);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    dispense("c13_poke", 13, 0, 4, 1);

    // Sweep all amounts with varying stalls
    for (int a = 1; a < 16; a++) begin
      n = push_greedy(a);
      dispense($sformatf("sweep%0d", a), a, a % 3, n, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter N, default 4: width of change amount and coin count.
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 SHALL have port start  input  1  one-cycle request to dispense change_in.
REQ-005 SHALL have port change_in  input  N  change amount from the change subtractor DIFF output.
REQ-006 SHALL have port borrow_in  input  1  insufficient-payment flag from the change subtractor BORROW_OUT output.
REQ-007 SHALL have port coin_ack  input  1  hopper accepts the presented coin.
REQ-008 SHALL have port coin_valid  output  1  coin request presented to hopper.
REQ-009 SHALL have port coin_sel  output  2  denomination: 01=1, 10=2, 11=5, 00=none.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when change is fully dispensed.
REQ-012 SHALL have port err  output  1  one-cycle pulse when a start arrives with borrow_in=1.
REQ-013 SHALL have port coins_out  output  N  number of coins dispensed for the last accepted request.

Function
REQ-014 SHALL implement an FSM with states IDLE, DISPENSE, DONE and ERR; all outputs are registered or decoded from state and registers only.
REQ-015 IDLE: start=1 with borrow_in=1 SHALL go to ERR and leave the remaining-amount register and coins_out unchanged.
REQ-016 IDLE: start=1, borrow_in=0, change_in=0 SHALL go to DONE and clear coins_out to 0.
REQ-017 IDLE: start=1, borrow_in=0, change_in!=0 SHALL latch remaining<=change_in, clear coins_out to 0 and go to DISPENSE.
REQ-018 Latency SHALL be exactly one cycle: start sampled at edge k gives coin_valid, done or err high in the cycle after edge k.
REQ-019 DISPENSE: coin_valid SHALL be 1, with coin_sel chosen greedily from remaining: remaining>=5 gives 11, remaining>=2 gives 10, otherwise 01.
REQ-020 coin_sel and coin_valid SHALL hold stable while coin_valid=1 and coin_ack=0 (backpressure of any length).
REQ-021 On a DISPENSE edge with coin_ack=1, the block SHALL subtract the coin value from remaining (N bits, no underflow possible) and increment coins_out by 1.
REQ-022 After an acked coin, the block SHALL go to DONE if the new remaining is 0 and otherwise stay in DISPENSE and present the next coin in the following cycle, giving at most one coin per cycle.
REQ-023 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE; ERR SHALL assert err=1 for exactly one cycle and then return to IDLE.
REQ-024 coin_valid SHALL be 0 and coin_sel SHALL be 00 in every state except DISPENSE.
REQ-025 start SHALL be ignored whenever busy=1; coin_ack SHALL be ignored outside DISPENSE.
REQ-026 coins_out SHALL hold its value from DONE until the next accepted non-error start.
REQ-027 The block SHALL never assert done and err in the same cycle.

Reset
REQ-028 On an edge with rst=1 the FSM SHALL go to IDLE, and remaining and coins_out SHALL become 0.
REQ-029 After reset, coin_valid=0, coin_sel=00, busy=0, done=0 and err=0 SHALL hold.
REQ-030 rst SHALL take priority over start and coin_ack on the same edge.
REQ-031 A reset during DISPENSE, DONE or ERR SHALL abort the request with no done or err pulse.

Verification
REQ-032 start, change_in=13, borrow_in=0, coin_ack tied 1 -> coin_sel sequence 11,11,10,01 on consecutive cycles, then done pulse, coins_out=4.
REQ-033 start, change_in=9, borrow_in=1 -> err=1 for exactly one cycle at k+1, coin_valid never asserted, busy back to 0 at k+2.
REQ-034 start, change_in=0, borrow_in=0 -> done=1 at k+1, coins_out=0, coin_valid never asserted.
REQ-035 start, change_in=7, coin_ack held 0 for 3 cycles then 1 -> coin_sel=11 stable for 4 cycles, then 10, then done, coins_out=2.
REQ-036 change_in=13, rst asserted after the first ack -> all outputs 0 next cycle with no done; then start, change_in=3 -> coin_sel 10, 01, done, coins_out=2.
REQ-037 start pulsed again during DISPENSE with change_in=15 -> ignored; the original sequence and coins_out are unaffected.
